multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Moore-FSM control unit for the multicycle RV32I core variant. It sequences a shared-memory datapath with a shared ALU over 3–5 cycles per instruction.
- The datapath has one memory port for instruction and data, plus IR, old-PC, data and ALU-out registers.
- Decodes op/funct fields into mux selects, register enables and ALUControl, reusing the single-cycle ALUControl encoding.
- Supports lw, sw, R-type, I-type ALU, beq and jal.

Parameters:
- none (ISA subset fixed; encodings in package)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  7  Instr[6:0] from IR
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- zero  in  1  ALU zero flag
- ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- AdrSrc  out  1  memory address: 0 PC, 1 Result
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- IRWrite  out  1  IR/OldPC load enable
- PCWrite  out  1  PC load enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  memory write enable
- state  out  4  current state (debug/verification)

Behaviour:
- States and encodings (4 bits, 0..10):
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5
  - EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10
  - Encodings 11–15 are illegal and transition to FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: lw/sw -> MEMADR; R -> EXECUTER; I -> EXECUTEI; jal -> JAL; beq -> BEQ; unknown op -> FETCH (instruction skipped, no write enables).
  - MEMADR: lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER, EXECUTEI and JAL -> ALUWB -> FETCH.
  - BEQ -> FETCH.
- Outputs per state; unlisted outputs are 0:
  - FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ALUOp add, ResultSrc 10, PCUpdate 1.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp add (branch target).
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp add.
  - MEMREAD: ResultSrc 00, AdrSrc 1.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1.
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp funct.
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp funct.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp add, ResultSrc 00, PCUpdate 1.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp sub, ResultSrc 00, Branch 1.
- PCWrite = PCUpdate | (Branch & zero); combinational from state and zero.
- ImmSrc is decoded from op in every state: lw/I 00, sw 01, beq 10, jal 11, other 00.
- ALU decode for ALUOp funct, by funct3:
  - 000: sub if op[5] & funct7b5, else add
  - 010: slt
  - 110: or
  - 111: and
  - other: add
- Cycle counts: lw 5, sw 4, R/I/jal 4, beq 3.
- Reset:
  - Asynchronous; state = FETCH immediately.
  - While reset is high, IRWrite, PCWrite, RegWrite and MemWrite are forced 0; selects show FETCH values.
  - Reset mid-instruction abandons it; the first cycle after deassertion is FETCH.

Optional Feature:
- Macro: MC_MEMREADY_EN.
- When defined:
  - Adds input mem_ready (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold their state until mem_ready=1.
  - In FETCH, IRWrite and PCWrite assert only in the cycle mem_ready=1.
  - MemWrite and AdrSrc stay asserted throughout a MEMWRITE stall.
  - MEMREAD advances to MEMWB only when mem_ready=1.
- When undefined: no port; behaves as mem_ready tied 1.

Decomposition:
- Shared package mc_pkg holds:
  - state encodings
  - opcode constants: OP_LW 0000011, OP_SW 0100011, OP_R 0110011, OP_I 0010011, OP_BEQ 1100011, OP_JAL 1101111
  - ALUOp (00 add, 01 sub, 10 funct)
  - ALUControl encodings
- One sub-module, mc_aludec: combinational ALUOp/funct3/funct7b5/op[5] -> ALUControl.

Test Plan:
- Assert reset for 3 cycles mid-stream -> state=0 asynchronously, all four write enables 0 during reset; first post-reset cycle IRWrite=1, PCWrite=1.
- lw x5,8(x0), IR=0x00802283 -> states 0,1,2,3,4. AdrSrc=1 in state 3; RegWrite=1 and ResultSrc=01 only in state 4; ImmSrc=00.
- sw x6,4(x0), IR=0x00602223 -> states 0,1,2,5. MemWrite=1 only in state 5; ImmSrc=01; RegWrite never asserted.
- add x7,x5,x6 (0x006283B3) -> ALUControl 000 in state 6. sub (0x406283B3) -> 001. addi with funct7b5=1 (0x40028393) -> 000. Each then reaches ALUWB with RegWrite=1.
- beq, IR=0x00000463 -> states 0,1,10. zero=1 gives PCWrite=1 in state 10 with ALUControl 001; zero=0 gives PCWrite=0.
- jal 0x008000EF -> PCWrite=1 in state 9 and RegWrite=1 in state 7. Illegal op 0x0000007F -> 0,1,0 with no write enables. With MC_MEMREADY_EN, mem_ready low 2 cycles in FETCH -> state held 3 cycles, IRWrite pulses once.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALUOp and ALUControl codes, and the immediate-format decode.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   return 2'b01;
      OP_BEQ:  return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps ALUOp plus instruction function fields onto ALUControl,
// using the same encoding as the single-cycle core.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type uses funct7b5; in I-type that bit is immediate data.
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM controller for the multicycle RV32I datapath (lw, sw, R, I, beq, jal).
// Define MC_MEMREADY_EN to add a mem_ready handshake that stalls memory states.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
`ifdef MC_MEMREADY_EN
  input  logic       mem_ready,
`endif
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [2:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic [1:0] aluop;
  logic       ready;
  logic       pc_update, branch, ir_write, reg_write, mem_write;

`ifdef MC_MEMREADY_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // NOTE: every output gets a default before the case, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d   = S_FETCH;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    aluop     = ALUOP_ADD;
    ir_write  = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = ready;
        pc_update = ready;
        state_d   = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        state_d   = ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset only masks the enables; selects already show FETCH via the async reset.
  assign IRWrite  = ir_write & ~reset;
  assign PCWrite  = (pc_update | (branch & zero)) & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign ImmSrc   = imm_src(op);
  assign state    = state_q;

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (ALUControl)
  );

endmodule
